// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 request arbiter: FSM states, requester ids, line geometry.
package l2_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    localparam int LINE_BYTES = 64;
endpackage

// File: rtl/arb_rr_sel.sv
// Two-way round-robin pick between I-cache and D-cache miss requests.
module arb_rr_sel
    import l2_arb_pkg::*;
(
    input  logic    ic_req,
    input  logic    dc_req,
    input  req_id_e last_gnt,
    output logic    win_valid,
    output req_id_e win_id
);
    always_comb begin
        win_valid = ic_req | dc_req;
        win_id    = REQ_IC;
        if (ic_req && dc_req)
            win_id = (last_gnt == REQ_IC) ? REQ_DC : REQ_IC;
        else if (dc_req)
            win_id = REQ_DC;
    end
endmodule

// File: rtl/l2_req_arbiter.sv
// Shares one next-level line-fill port between I-cache and D-cache miss paths.
// Optional grant/wait statistics counters are enabled with `define ARB_STATS_EN.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int OFFS_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_valid,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_gnt,
    output logic              dc_valid,
    output logic [LINE_W-1:0] fill_data,
    output logic              nl_req,
    output logic [ADDR_W-1:0] nl_addr,
    input  logic              nl_ack,
    input  logic [LINE_W-1:0] nl_data,
    output logic              busy,
    output logic              timeout_err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       ic_grant_cnt,
    output logic [31:0]       dc_grant_cnt,
    output logic [31:0]       wait_cyc_cnt
`endif
);
    localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);
    localparam logic [7:0]        TO_LIM    = 8'(TIMEOUT);

    arb_state_e        state_q, state_d;
    req_id_e           last_q, last_d, win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic              first_q, first_d;

    logic    win_valid;
    req_id_e win_id;

    arb_rr_sel u_sel (
        .ic_req   (ic_req),
        .dc_req   (dc_req),
        .last_gnt (last_q),
        .win_valid(win_valid),
        .win_id   (win_id)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        addr_d  = addr_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    win_d   = win_id;
                    last_d  = win_id;
                    addr_d  = ((win_id == REQ_DC) ? dc_addr : ic_addr) & ~OFFS_MASK;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (nl_ack) begin
                    fill_d  = nl_data;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == TO_LIM) begin
                    terr_d  = 1'b1;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_IC;
            win_q   <= REQ_IC;
            addr_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            first_q <= first_d;
        end
    end

    assign ic_gnt      = first_q && (win_q == REQ_IC);
    assign dc_gnt      = first_q && (win_q == REQ_DC);
    assign ic_valid    = (state_q == RESP) && (win_q == REQ_IC);
    assign dc_valid    = (state_q == RESP) && (win_q == REQ_DC);
    assign nl_req      = (state_q == ISSUE);
    assign nl_addr     = addr_q;
    assign fill_data   = fill_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;

`ifdef ARB_STATS_EN
    logic [31:0] icg_q, dcg_q, wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            icg_q  <= '0;
            dcg_q  <= '0;
            wait_q <= '0;
        end else begin
            if (ic_gnt)             icg_q  <= icg_q + 32'd1;
            if (dc_gnt)             dcg_q  <= dcg_q + 32'd1;
            if (state_q == ISSUE)   wait_q <= wait_q + 32'd1;
        end
    end

    assign ic_grant_cnt = icg_q;
    assign dc_grant_cnt = dcg_q;
    assign wait_cyc_cnt = wait_q;
`endif
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Scoreboard bench for l2_req_arbiter: requester and next-level models, grant/fill checks.
module tb_l2_req_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req = 1'b0, dc_req = 1'b0;
    logic [31:0]  ic_addr = '0, dc_addr = '0;
    logic         ic_gnt, ic_valid, dc_gnt, dc_valid;
    logic [511:0] fill_data;
    logic         nl_req;
    logic [31:0]  nl_addr;
    logic         nl_ack = 1'b0;
    logic [511:0] nl_data = '0;
    logic         busy, timeout_err;
`ifdef ARB_STATS_EN
    logic [31:0]  ic_grant_cnt, dc_grant_cnt, wait_cyc_cnt;
`endif

    l2_req_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_valid(ic_valid),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_gnt(dc_gnt), .dc_valid(dc_valid),
        .fill_data(fill_data), .nl_req(nl_req), .nl_addr(nl_addr),
        .nl_ack(nl_ack), .nl_data(nl_data), .busy(busy), .timeout_err(timeout_err)
`ifdef ARB_STATS_EN
        , .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt), .wait_cyc_cnt(wait_cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [31:0]  addr;
        logic [511:0] data;
        logic         tout;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  ic_q[$], dc_q[$];
    logic         ic_out = 1'b0, dc_out = 1'b0;
    int           errs = 0, checks = 0;
    int           cyc = 0, g_cyc = 0, vld_seen = 0;
    int           ack_dly = 0, iss_n = 0;
    logic         force_ack = 1'b0, use_fix = 1'b0;
    logic [511:0] fix_data = '0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] line_of(input logic [31:0] a);
        return {16{a ^ 32'h5A5A_5A5A}};
    endfunction

    task automatic expect_txn(input logic id, input logic [31:0] a, input logic [511:0] d,
                              input logic tout, input int lat);
        exp_t e;
        e.id = id; e.addr = a; e.data = d; e.tout = tout; e.lat = lat;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Requester models: hold req until gnt, next request only after the valid pulse.
    always @(negedge clk) begin
        if (rst) begin
            ic_out = 1'b0; ic_req = 1'b0;
        end else begin
            if (ic_gnt) begin ic_req = 1'b0; ic_q.delete(0); ic_out = 1'b1; end
            if (ic_valid) ic_out = 1'b0;
            if (!ic_out && !ic_req && ic_q.size() > 0) begin ic_req = 1'b1; ic_addr = ic_q[0]; end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            dc_out = 1'b0; dc_req = 1'b0;
        end else begin
            if (dc_gnt) begin dc_req = 1'b0; dc_q.delete(0); dc_out = 1'b1; end
            if (dc_valid) dc_out = 1'b0;
            if (!dc_out && !dc_req && dc_q.size() > 0) begin dc_req = 1'b1; dc_addr = dc_q[0]; end
        end
    end

    // Next-level model: ack after ack_dly ISSUE cycles.
    always @(negedge clk) begin
        if (nl_req) begin
            nl_ack  = (iss_n == ack_dly) | force_ack;
            nl_data = use_fix ? fix_data : line_of(nl_addr);
            iss_n++;
        end else begin
            iss_n  = 0;
            nl_ack = force_ack;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (ic_gnt || dc_gnt) begin
                if (exp_q.size() == 0) chk("gnt_unexpected", 1'b1, 1'b0);
                else begin
                    chk("gnt_both", ic_gnt & dc_gnt, 1'b0);
                    chk("gnt_id", dc_gnt, exp_q[0].id);
                    chk("nl_addr", nl_addr, exp_q[0].addr);
                    chk("nl_req_at_gnt", nl_req, 1'b1);
                    g_cyc = cyc;
                end
            end
            if (ic_valid || dc_valid) begin
                vld_seen++;
                if (exp_q.size() == 0) chk("valid_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("valid_both", ic_valid & dc_valid, 1'b0);
                    chk("valid_id", dc_valid, e.id);
                    chk("fill_data", fill_data, e.data);
                    chk("timeout_err", timeout_err, e.tout);
                    chk("latency", cyc - g_cyc, e.lat);
                    chk("nl_req_in_resp", nl_req, 1'b0);
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ic_q.size() != 0 || dc_q.size() != 0 ||
                ic_out || dc_out || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_nl_req"}, nl_req, 1'b0);
        chk({tag, "_nl_addr"}, nl_addr, 32'h0);
        chk({tag, "_fill"}, fill_data, 512'h0);
        chk({tag, "_terr"}, timeout_err, 1'b0);
        chk({tag, "_gnts"}, {ic_gnt, dc_gnt}, 2'b00);
        chk({tag, "_valids"}, {ic_valid, dc_valid}, 2'b00);
    endtask

    initial begin
        int n, v0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
`ifdef ARB_STATS_EN
        chk("reset_stats", {ic_grant_cnt, dc_grant_cnt, wait_cyc_cnt}, 96'h0);
`endif
        rst = 1'b0;

        // Single D-cache miss, ack three cycles after nl_req.
        use_fix = 1'b1; fix_data = {16{32'hA5A5_A5A5}}; ack_dly = 3;
        expect_txn(1'b1, 32'h1234_5640, fix_data, 1'b0, 4);
        dc_q.push_back(32'h1234_567F);
        drain(50);
        use_fix = 1'b0;

        // Both request from reset, continuous contention, ack in first ISSUE cycle.
        do_reset();
        ack_dly = 0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] da, ia;
            da = 32'h8000_0000 + 32'(i * 'h1C3);
            ia = 32'h0040_0000 + 32'(i * 'h2B5);
            dc_q.push_back(da);
            ic_q.push_back(ia);
            expect_txn(1'b1, da & ~32'h3F, line_of(da & ~32'h3F), 1'b0, 1);
            expect_txn(1'b0, ia & ~32'h3F, line_of(ia & ~32'h3F), 1'b0, 1);
        end
        drain(100);

        // Timeout on an I-cache miss, then a good D-cache miss keeps the sticky flag.
        chk("terr_before", timeout_err, 1'b0);
        ack_dly = 100000;
        expect_txn(1'b0, 32'hDEAD_BEC0, 512'h0, 1'b1, 256);
        ic_q.push_back(32'hDEAD_BEEF);
        drain(400);
        chk("terr_after", timeout_err, 1'b1);
        ack_dly = 1;
        expect_txn(1'b1, 32'h0000_0FC0, line_of(32'h0000_0FC0), 1'b1, 2);
        dc_q.push_back(32'h0000_0FFF);
        drain(50);
        chk("terr_sticky", timeout_err, 1'b1);

        // Reset in the middle of ISSUE drops the transaction.
        ack_dly = 100000;
        expect_txn(1'b0, 32'h0000_1000, 512'h0, 1'b0, 1);
        ic_q.push_back(32'h0000_1004);
        n = 0;
        while (!nl_req && n < 20) begin @(negedge clk); n++; end
        chk("mid_issue_reached", n < 20, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("mid_rst");
        @(negedge clk); rst = 1'b0;
        v0 = vld_seen;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_ack_no_valid", vld_seen - v0, 0);
        chk("late_ack_busy", busy, 1'b0);

        // Mixed traffic, four ISSUE cycles each: DC, IC, DC, IC, DC.
        do_reset();
        ack_dly = 3;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'hC000_0000 | 32'(i << 8);
            dc_q.push_back(a);
            expect_txn(1'b1, a, line_of(a), 1'b0, 4);
            if (i < 2) begin
                a = 32'h1000_0000 | 32'(i << 12) | 32'h11;
                ic_q.push_back(a);
                expect_txn(1'b0, a & ~32'h3F, line_of(a & ~32'h3F), 1'b0, 4);
            end
        end
        drain(200);
`ifdef ARB_STATS_EN
        chk("dc_grant_cnt", dc_grant_cnt, 32'd3);
        chk("ic_grant_cnt", ic_grant_cnt, 32'd2);
        chk("wait_cyc_cnt", wait_cyc_cnt, 32'd20);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end
endmodule
